lc3bp_mem_stage: RTL and testbench

MEM stage of the LC-3b pipeline. Sits directly downstream of AGEX. Latches the AGEX result, performs the data-memory access (byte/word, multi-cycle ready handshake), and resolves branches, JMP/JSR and TRAP. Produces the stall, PC-select and register/CC-forwarding signals consumed by fetch, decode and AGEX, and the SR latches consumed by the store-result stage.

---
 rtl/lc3bp_mem_stage_if.sv | 28 ++
 rtl/lc3bp_mem_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_lc3bp_mem_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3bp_mem_stage_if.sv
// Data-memory port of the LC-3b MEM stage: request (enable, byte enables,
// address, write data) and response (read data, access-complete strobe).
interface lc3bp_mem_stage_if;
    logic        en;
    logic [1:0]  we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        r;

    modport master (
        output en,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  r
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output r
    );
endinterface

// File: rtl/lc3bp_mem_stage.sv
// LC-3b pipeline MEM stage: latches AGEX results, runs the data-memory access,
// resolves control flow and feeds the SR latches plus forwarding/stall info.
module lc3bp_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        agex_v,
    input  logic [15:0] agex_npc,
    input  logic [15:0] agex_ir,
    input  logic [15:0] agex_address,
    input  logic [15:0] agex_alu_result,
    input  logic [2:0]  agex_cc,
    input  logic [2:0]  agex_drid,
    input  logic        agex_ld_reg,
    input  logic        agex_ld_cc,
    input  logic        agex_dcache_en,
    input  logic        agex_dcache_rw,
    input  logic        agex_data_size,
    input  logic        agex_br_op,
    input  logic        agex_uncond_op,
    input  logic        agex_trap_op,
    input  logic [1:0]  agex_dr_mux,
    input  logic [15:0] agex_store_data,
    lc3bp_mem_stage_if.master dmem,
    output logic        mem_stall,
    output logic        v_mem_br_stall,
    output logic [1:0]  mem_pcmux,
    output logic [15:0] mem_target_pc,
    output logic        v_mem_ld_reg,
    output logic        v_mem_ld_cc,
    output logic [2:0]  mem_drid,
    output logic        sr_v,
    output logic        sr_ld_reg,
    output logic        sr_ld_cc,
    output logic [2:0]  sr_drid,
    output logic [15:0] sr_data,
    output logic [15:0] stall_cycles
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;

    logic        v_q, v_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] address_q, address_d;
    logic [15:0] alu_q, alu_d;
    logic [2:0]  cc_q, cc_d;
    logic [2:0]  drid_q, drid_d;
    logic        ld_reg_q, ld_reg_d;
    logic        ld_cc_q, ld_cc_d;
    logic        dcache_en_q, dcache_en_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic        br_op_q, br_op_d;
    logic        uncond_q, uncond_d;
    logic        trap_q, trap_d;
    logic [1:0]  dr_mux_q, dr_mux_d;
    logic [15:0] store_q, store_d;

    logic        sr_v_q, sr_v_d;
    logic        sr_ld_reg_q, sr_ld_reg_d;
    logic        sr_ld_cc_q, sr_ld_cc_d;
    logic [2:0]  sr_drid_q, sr_drid_d;
    logic [15:0] sr_data_q, sr_data_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic        mem_op;
    logic        stall;
    logic        br_taken;
    logic [7:0]  rd_byte;
    logic [15:0] mem_data;

    // Only the branch condition field of IR is consumed here
    logic        unused_ir_bits;
    assign unused_ir_bits = ^{ir_q[15:12], ir_q[8:0]};

    always_comb begin
        mem_op   = v_q & dcache_en_q;
        stall    = mem_op & ~dmem.r;
        br_taken = br_op_q & (|(ir_q[11:9] & cc_q));
        rd_byte  = address_q[0] ? dmem.rdata[15:8] : dmem.rdata[7:0];
        mem_data = size_q ? dmem.rdata : {{8{rd_byte[7]}}, rd_byte};
    end

    // Request path; WAIT keeps the request up with the held latches
    always_comb begin
        state_d    = state_q;
        dmem.en    = 1'b0;
        dmem.we    = 2'b00;
        dmem.addr  = size_q ? {address_q[15:1], 1'b0} : address_q;
        dmem.wdata = size_q ? store_q : {store_q[7:0], store_q[7:0]};
        case (state_q)
            IDLE: begin
                dmem.en = mem_op;
                if (mem_op && !dmem.r) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                dmem.en = 1'b1;
                if (dmem.r) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (dmem.en && rw_q) begin
            dmem.we = size_q ? 2'b11 : (address_q[0] ? 2'b10 : 2'b01);
        end
    end

    always_comb begin
        mem_stall      = stall;
        v_mem_br_stall = v_q & (br_op_q | uncond_q | trap_q);
        v_mem_ld_reg   = v_q & ld_reg_q;
        v_mem_ld_cc    = v_q & ld_cc_q;
        mem_drid       = drid_q;
        mem_pcmux      = 2'b00;
        mem_target_pc  = address_q;
        if (v_q && !stall) begin
            if (trap_q) begin
                mem_pcmux     = 2'b10;
                mem_target_pc = mem_data;
            end else if (uncond_q || br_taken) begin
                mem_pcmux = 2'b01;
            end
        end
    end

    always_comb begin
        v_d         = v_q;
        npc_d       = npc_q;
        ir_d        = ir_q;
        address_d   = address_q;
        alu_d       = alu_q;
        cc_d        = cc_q;
        drid_d      = drid_q;
        ld_reg_d    = ld_reg_q;
        ld_cc_d     = ld_cc_q;
        dcache_en_d = dcache_en_q;
        rw_d        = rw_q;
        size_d      = size_q;
        br_op_d     = br_op_q;
        uncond_d    = uncond_q;
        trap_d      = trap_q;
        dr_mux_d    = dr_mux_q;
        store_d     = store_q;
        if (!stall) begin
            v_d         = agex_v;
            npc_d       = agex_npc;
            ir_d        = agex_ir;
            address_d   = agex_address;
            alu_d       = agex_alu_result;
            cc_d        = agex_cc;
            drid_d      = agex_drid;
            ld_reg_d    = agex_ld_reg;
            ld_cc_d     = agex_ld_cc;
            dcache_en_d = agex_dcache_en;
            rw_d        = agex_dcache_rw;
            size_d      = agex_data_size;
            br_op_d     = agex_br_op;
            uncond_d    = agex_uncond_op;
            trap_d      = agex_trap_op;
            dr_mux_d    = agex_dr_mux;
            store_d     = agex_store_data;
        end

        // SR always loads; a stall becomes a bubble through sr_v
        sr_v_d      = v_q & ~stall;
        sr_ld_reg_d = ld_reg_q;
        sr_ld_cc_d  = ld_cc_q;
        sr_drid_d   = drid_q;
        case (dr_mux_q)
            2'b00:   sr_data_d = address_q;
            2'b01:   sr_data_d = mem_data;
            2'b10:   sr_data_d = npc_q;
            default: sr_data_d = alu_q;
        endcase

        stall_cycles_d = stall_cycles_q;
        if (stall && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            v_q            <= 1'b0;
            npc_q          <= 16'h0000;
            ir_q           <= 16'h0000;
            address_q      <= 16'h0000;
            alu_q          <= 16'h0000;
            cc_q           <= 3'b000;
            drid_q         <= 3'b000;
            ld_reg_q       <= 1'b0;
            ld_cc_q        <= 1'b0;
            dcache_en_q    <= 1'b0;
            rw_q           <= 1'b0;
            size_q         <= 1'b0;
            br_op_q        <= 1'b0;
            uncond_q       <= 1'b0;
            trap_q         <= 1'b0;
            dr_mux_q       <= 2'b00;
            store_q        <= 16'h0000;
            sr_v_q         <= 1'b0;
            sr_ld_reg_q    <= 1'b0;
            sr_ld_cc_q     <= 1'b0;
            sr_drid_q      <= 3'b000;
            sr_data_q      <= 16'h0000;
            stall_cycles_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            v_q            <= v_d;
            npc_q          <= npc_d;
            ir_q           <= ir_d;
            address_q      <= address_d;
            alu_q          <= alu_d;
            cc_q           <= cc_d;
            drid_q         <= drid_d;
            ld_reg_q       <= ld_reg_d;
            ld_cc_q        <= ld_cc_d;
            dcache_en_q    <= dcache_en_d;
            rw_q           <= rw_d;
            size_q         <= size_d;
            br_op_q        <= br_op_d;
            uncond_q       <= uncond_d;
            trap_q         <= trap_d;
            dr_mux_q       <= dr_mux_d;
            store_q        <= store_d;
            sr_v_q         <= sr_v_d;
            sr_ld_reg_q    <= sr_ld_reg_d;
            sr_ld_cc_q     <= sr_ld_cc_d;
            sr_drid_q      <= sr_drid_d;
            sr_data_q      <= sr_data_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sr_v         = sr_v_q;
    assign sr_ld_reg    = sr_ld_reg_q;
    assign sr_ld_cc     = sr_ld_cc_q;
    assign sr_drid      = sr_drid_q;
    assign sr_data      = sr_data_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_lc3bp_mem_stage.sv
// Directed bench for lc3bp_mem_stage: inputs change 1ns after the rising edge,
// outputs are checked on the falling edge against hand-computed values.
module tb_lc3bp_mem_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        agex_v;
    logic [15:0] agex_npc, agex_ir, agex_address, agex_alu_result, agex_store_data;
    logic [2:0]  agex_cc, agex_drid;
    logic        agex_ld_reg, agex_ld_cc, agex_dcache_en, agex_dcache_rw, agex_data_size;
    logic        agex_br_op, agex_uncond_op, agex_trap_op;
    logic [1:0]  agex_dr_mux;
    logic        mem_stall, v_mem_br_stall, v_mem_ld_reg, v_mem_ld_cc;
    logic [1:0]  mem_pcmux;
    logic [15:0] mem_target_pc, sr_data, stall_cycles;
    logic [2:0]  mem_drid, sr_drid;
    logic        sr_v, sr_ld_reg, sr_ld_cc;

    int checks = 0;
    int failures = 0;

    lc3bp_mem_stage_if dmem_bus ();

    lc3bp_mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .agex_v          (agex_v),
        .agex_npc        (agex_npc),
        .agex_ir         (agex_ir),
        .agex_address    (agex_address),
        .agex_alu_result (agex_alu_result),
        .agex_cc         (agex_cc),
        .agex_drid       (agex_drid),
        .agex_ld_reg     (agex_ld_reg),
        .agex_ld_cc      (agex_ld_cc),
        .agex_dcache_en  (agex_dcache_en),
        .agex_dcache_rw  (agex_dcache_rw),
        .agex_data_size  (agex_data_size),
        .agex_br_op      (agex_br_op),
        .agex_uncond_op  (agex_uncond_op),
        .agex_trap_op    (agex_trap_op),
        .agex_dr_mux     (agex_dr_mux),
        .agex_store_data (agex_store_data),
        .dmem            (dmem_bus.master),
        .mem_stall       (mem_stall),
        .v_mem_br_stall  (v_mem_br_stall),
        .mem_pcmux       (mem_pcmux),
        .mem_target_pc   (mem_target_pc),
        .v_mem_ld_reg    (v_mem_ld_reg),
        .v_mem_ld_cc     (v_mem_ld_cc),
        .mem_drid        (mem_drid),
        .sr_v            (sr_v),
        .sr_ld_reg       (sr_ld_reg),
        .sr_ld_cc        (sr_ld_cc),
        .sr_drid         (sr_drid),
        .sr_data         (sr_data),
        .stall_cycles    (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_agex();
        agex_v = 0; agex_npc = 0; agex_ir = 0; agex_address = 0; agex_alu_result = 0;
        agex_cc = 0; agex_drid = 0; agex_ld_reg = 0; agex_ld_cc = 0; agex_dcache_en = 0;
        agex_dcache_rw = 0; agex_data_size = 0; agex_br_op = 0; agex_uncond_op = 0;
        agex_trap_op = 0; agex_dr_mux = 0; agex_store_data = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        clear_agex();
        reset = 1'b1;
        dmem_bus.r = 1'b0;
        dmem_bus.rdata = 16'h0000;
        step(); step();
        sample();
        chk("rst_sr_v", {15'd0, sr_v}, 16'd0);
        chk("rst_dmem_en", {15'd0, dmem_bus.en}, 16'd0);
        chk("rst_dmem_we", {14'd0, dmem_bus.we}, 16'd0);
        chk("rst_stall", {15'd0, mem_stall}, 16'd0);
        chk("rst_pcmux", {14'd0, mem_pcmux}, 16'd0);
        chk("rst_br_stall", {15'd0, v_mem_br_stall}, 16'd0);
        chk("rst_ld_reg", {15'd0, v_mem_ld_reg}, 16'd0);
        chk("rst_ld_cc", {15'd0, v_mem_ld_cc}, 16'd0);
        chk("rst_stall_cycles", stall_cycles, 16'd0);
        chk("rst_sr_data", sr_data, 16'd0);

        // ALU op
        step();
        reset = 1'b0;
        agex_v = 1; agex_alu_result = 16'h1234; agex_dr_mux = 2'b11; agex_ld_reg = 1; agex_drid = 3;
        step(); clear_agex();
        sample();
        $display("txn ALU in MEM: stall=%0d ld_reg=%0d drid=%0d", mem_stall, v_mem_ld_reg, mem_drid);
        chk("alu_stall", {15'd0, mem_stall}, 16'd0);
        chk("alu_v_ld_reg", {15'd0, v_mem_ld_reg}, 16'd1);
        chk("alu_mem_drid", {13'd0, mem_drid}, 16'd3);
        chk("alu_dmem_en", {15'd0, dmem_bus.en}, 16'd0);
        step();
        sample();
        $display("txn ALU in SR: sr_v=%0d sr_data=%h", sr_v, sr_data);
        chk("alu_sr_v", {15'd0, sr_v}, 16'd1);
        chk("alu_sr_data", sr_data, 16'h1234);
        chk("alu_sr_drid", {13'd0, sr_drid}, 16'd3);
        chk("alu_sr_ld_reg", {15'd0, sr_ld_reg}, 16'd1);

        // LDB 0x3001, two wait cycles
        agex_v = 1; agex_address = 16'h3001; agex_dcache_en = 1; agex_dr_mux = 2'b01;
        agex_ld_reg = 1; agex_ld_cc = 1; agex_drid = 2;
        dmem_bus.rdata = 16'h80FF;
        step(); clear_agex();
        sample();
        chk("ldb_addr", dmem_bus.addr, 16'h3001);
        chk("ldb_en", {15'd0, dmem_bus.en}, 16'd1);
        chk("ldb_we", {14'd0, dmem_bus.we}, 16'd0);
        chk("ldb_stall0", {15'd0, mem_stall}, 16'd1);
        chk("ldb_sr_v_bubble", {15'd0, sr_v}, 16'd0);
        step();
        sample();
        chk("ldb_stall1", {15'd0, mem_stall}, 16'd1);
        chk("ldb_addr_held", dmem_bus.addr, 16'h3001);
        step();
        dmem_bus.r = 1'b1;
        sample();
        chk("ldb_stall2", {15'd0, mem_stall}, 16'd0);
        chk("ldb_stall_cycles", stall_cycles, 16'd2);
        chk("ldb_v_ld_cc", {15'd0, v_mem_ld_cc}, 16'd1);
        step();
        dmem_bus.r = 1'b0;
        sample();
        $display("txn LDB: sr_v=%0d sr_data=%h stall_cycles=%0d", sr_v, sr_data, stall_cycles);
        chk("ldb_sr_v", {15'd0, sr_v}, 16'd1);
        chk("ldb_sr_data", sr_data, 16'hFF80);
        chk("ldb_sr_ld_cc", {15'd0, sr_ld_cc}, 16'd1);
        chk("ldb_stall_cycles_after", stall_cycles, 16'd2);

        // STB 0x4000, immediate ready
        agex_v = 1; agex_address = 16'h4000; agex_dcache_en = 1; agex_dcache_rw = 1;
        agex_store_data = 16'hABCD;
        dmem_bus.r = 1'b1;
        step(); clear_agex();
        sample();
        $display("txn STB: addr=%h we=%b wdata=%h stall=%0d", dmem_bus.addr, dmem_bus.we, dmem_bus.wdata, mem_stall);
        chk("stb_we", {14'd0, dmem_bus.we}, 16'h0001);
        chk("stb_wdata", dmem_bus.wdata, 16'hCDCD);
        chk("stb_stall", {15'd0, mem_stall}, 16'd0);
        chk("stb_addr", dmem_bus.addr, 16'h4000);

        // STW 0x4003 completing as an ALU op arrives behind it
        agex_v = 1; agex_address = 16'h4003; agex_dcache_en = 1; agex_dcache_rw = 1;
        agex_data_size = 1; agex_store_data = 16'hABCD; agex_dr_mux = 2'b00;
        step();
        clear_agex();
        agex_v = 1; agex_alu_result = 16'h5555; agex_dr_mux = 2'b11; agex_ld_reg = 1; agex_drid = 5;
        sample();
        $display("txn STW: addr=%h we=%b wdata=%h", dmem_bus.addr, dmem_bus.we, dmem_bus.wdata);
        chk("stw_addr", dmem_bus.addr, 16'h4002);
        chk("stw_we", {14'd0, dmem_bus.we}, 16'h0003);
        chk("stw_wdata", dmem_bus.wdata, 16'hABCD);
        chk("stb_sr_v", {15'd0, sr_v}, 16'd1);
        step(); clear_agex();
        dmem_bus.r = 1'b0;
        sample();
        chk("b2b_sr_v", {15'd0, sr_v}, 16'd1);
        chk("b2b_sr_data", sr_data, 16'h4003);
        chk("b2b_sr_ld_reg", {15'd0, sr_ld_reg}, 16'd0);
        chk("b2b_mem_drid", {13'd0, mem_drid}, 16'd5);
        chk("b2b_v_ld_reg", {15'd0, v_mem_ld_reg}, 16'd1);
        step();
        sample();
        chk("b2b_alu_sr_data", sr_data, 16'h5555);

        // Invalid slot with dcache_en set: no request
        agex_v = 0; agex_dcache_en = 1; agex_address = 16'h1111;
        step(); clear_agex();
        sample();
        chk("inv_en", {15'd0, dmem_bus.en}, 16'd0);
        chk("inv_stall", {15'd0, mem_stall}, 16'd0);

        // BRz taken and not taken
        agex_v = 1; agex_ir = 16'h0400; agex_br_op = 1; agex_cc = 3'b010; agex_address = 16'h3050;
        step(); clear_agex();
        sample();
        $display("txn BRz cc=010: pcmux=%b target=%h br_stall=%0d", mem_pcmux, mem_target_pc, v_mem_br_stall);
        chk("brz_t_pcmux", {14'd0, mem_pcmux}, 16'd1);
        chk("brz_t_target", mem_target_pc, 16'h3050);
        chk("brz_t_br_stall", {15'd0, v_mem_br_stall}, 16'd1);
        agex_v = 1; agex_ir = 16'h0400; agex_br_op = 1; agex_cc = 3'b100; agex_address = 16'h3050;
        step(); clear_agex();
        sample();
        $display("txn BRz cc=100: pcmux=%b br_stall=%0d", mem_pcmux, v_mem_br_stall);
        chk("brz_nt_pcmux", {14'd0, mem_pcmux}, 16'd0);
        chk("brz_nt_br_stall", {15'd0, v_mem_br_stall}, 16'd1);

        // TRAP, three wait cycles
        agex_v = 1; agex_trap_op = 1; agex_dcache_en = 1; agex_data_size = 1;
        agex_address = 16'h0040; agex_npc = 16'h3002; agex_dr_mux = 2'b10; agex_ld_reg = 1; agex_drid = 7;
        dmem_bus.rdata = 16'h0200;
        step(); clear_agex();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk($sformatf("trap_wait%0d_pcmux", i), {14'd0, mem_pcmux}, 16'd0);
            chk($sformatf("trap_wait%0d_br_stall", i), {15'd0, v_mem_br_stall}, 16'd1);
            chk($sformatf("trap_wait%0d_stall", i), {15'd0, mem_stall}, 16'd1);
            step();
        end
        dmem_bus.r = 1'b1;
        sample();
        $display("txn TRAP complete: pcmux=%b target=%h stall_cycles=%0d", mem_pcmux, mem_target_pc, stall_cycles);
        chk("trap_pcmux", {14'd0, mem_pcmux}, 16'd2);
        chk("trap_target", mem_target_pc, 16'h0200);
        chk("trap_stall_cycles", stall_cycles, 16'd5);
        step();
        dmem_bus.r = 1'b0;
        sample();
        chk("trap_sr_v", {15'd0, sr_v}, 16'd1);
        chk("trap_sr_data", sr_data, 16'h3002);
        chk("trap_sr_drid", {13'd0, sr_drid}, 16'd7);

        // TRAP again, reset during the wait
        agex_v = 1; agex_trap_op = 1; agex_dcache_en = 1; agex_data_size = 1;
        agex_address = 16'h0040; agex_npc = 16'h3002; agex_dr_mux = 2'b10; agex_ld_reg = 1;
        step(); clear_agex();
        sample();
        chk("trap2_stall", {15'd0, mem_stall}, 16'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sample();
        $display("txn TRAP reset mid-wait: en=%0d stall=%0d sr_v=%0d", dmem_bus.en, mem_stall, sr_v);
        chk("rstw_en", {15'd0, dmem_bus.en}, 16'd0);
        chk("rstw_stall", {15'd0, mem_stall}, 16'd0);
        chk("rstw_pcmux", {14'd0, mem_pcmux}, 16'd0);
        chk("rstw_br_stall", {15'd0, v_mem_br_stall}, 16'd0);
        chk("rstw_sr_v", {15'd0, sr_v}, 16'd0);
        chk("rstw_ld_reg", {15'd0, v_mem_ld_reg}, 16'd0);
        chk("rstw_stall_cycles", stall_cycles, 16'd0);
        step();
        sample();
        chk("rstw_en_later", {15'd0, dmem_bus.en}, 16'd0);
        chk("rstw_sr_v_later", {15'd0, sr_v}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
